// File: rtl/i2c_pkg.sv
// Shared types and constants for the img2col weight sequencer.
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, HOLD, DONE} state_t;

  localparam int SKID_DEPTH   = 2;
  localparam int LANES_DEF    = 8;
  localparam int DATA_WID_DEF = 16;

  typedef logic [LANES_DEF-1:0][DATA_WID_DEF-1:0] lane_vec_t;
endpackage

// File: rtl/i2c_skid_fifo.sv
// Two-entry valid/ready FIFO with fall-through when empty; count feeds read-issue gating.
module i2c_skid_fifo
  import i2c_pkg::*;
#(
  parameter int WID = 129
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [WID-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WID-1:0] out_data,
  output logic [1:0]     count
);
  logic [WID-1:0] mem [SKID_DEPTH];
  logic           rd_ptr;
  logic           wr_ptr;
  logic           empty;
  logic           store;
  logic           deq;

  // An arriving word bypasses storage only when it is consumed in the same cycle.
  always_comb begin
    empty     = (count == 2'd0);
    wr_ptr    = rd_ptr ^ count[0];
    out_valid = !empty || in_valid;
    out_data  = !empty ? mem[rd_ptr] : (in_valid ? in_data : '0);
    store     = in_valid && !(empty && out_ready);
    deq       = !empty && out_ready;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
    end else begin
      if (deq) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, store} - {1'b0, deq};
    end
  end

  always_ff @(posedge clock) begin
    if (store) mem[wr_ptr] <= in_data;
  end
endmodule

// File: rtl/img2col_weight_pp.sv
// img2col weight sequencer: streams passes of C*K*K lane vectors, waiting for a bank swap between passes.
// Optional I2C_WGT_ZEROPAD_EN pads each pass with zero vectors up to a multiple of LANES.
module img2col_weight_pp
  import i2c_pkg::*;
#(
  parameter int DATA_WID = 16,
  parameter int LANES    = 8,
  parameter int ADDR_WID = 10,
  parameter int CHN_WID  = 4,
  parameter int KS_WID   = 4
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CHN_WID-1:0]        chn_per_pass,
  input  logic [CHN_WID-1:0]        num_passes,
  input  logic [KS_WID-1:0]         kernel_size,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err,
  output logic                      rd_en,
  output logic [ADDR_WID-1:0]       rd_addr,
  input  logic [LANES*DATA_WID-1:0] rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_WID-1:0] out_data,
  output logic                      out_last,
  output logic                      pass_done,
  input  logic                      swap_ack
);
  localparam int FW = 2*CHN_WID + 2*KS_WID;
  localparam int VW = LANES*DATA_WID;
  localparam logic [FW:0] ADDR_SPAN = {{FW{1'b0}}, 1'b1} << ADDR_WID;

  state_t            state, nxt;
  logic [FW-1:0]     e_calc, t_calc, v_calc, v_reg, elem;
  logic [CHN_WID-1:0] p_reg, pass_cnt;
  logic              cfg_bad, issue, real_rd, elem_last;
  logic              rd_pending, last_pending, swap_flag, accept_last;
  logic [1:0]        occ;
  logic              fifo_vld;
  logic [VW:0]       fifo_in, fifo_out;
`ifdef I2C_WGT_ZEROPAD_EN
  logic [FW-1:0]     e_reg;
  logic              pad_pending;
`endif

  always_comb begin
    e_calc  = FW'(chn_per_pass) * FW'(kernel_size) * FW'(kernel_size);
    t_calc  = FW'(num_passes) * e_calc;
    cfg_bad = (chn_per_pass == '0) || (num_passes == '0) || (kernel_size == '0) ||
              ({1'b0, t_calc} > ADDR_SPAN);
`ifdef I2C_WGT_ZEROPAD_EN
    // Pad slots reuse the in-flight slot of a read but never touch the upstream buffer.
    v_calc  = ((e_calc + FW'(LANES-1)) / FW'(LANES)) * FW'(LANES);
    real_rd = (elem < e_reg);
    fifo_in = {last_pending, pad_pending ? {VW{1'b0}} : rd_data};
`else
    v_calc  = e_calc;
    real_rd = 1'b1;
    fifo_in = {last_pending, rd_data};
`endif
    elem_last   = (elem == v_reg - FW'(1));
    issue       = (state == RUN) && ((occ + {1'b0, rd_pending}) < 2'(SKID_DEPTH));
    accept_last = fifo_vld && out_ready && fifo_out[VW];
  end

  always_ff @(posedge clock) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = cfg_bad ? DONE : RUN;
      RUN:     if (issue && elem_last) nxt = DRAIN;
      DRAIN:   if (accept_last) nxt = (pass_cnt == p_reg - CHN_WID'(1)) ? DONE : HOLD;
      HOLD:    if (swap_ack || swap_flag) nxt = RUN;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN) || (state == DRAIN) || (state == HOLD);
    done      = (state == DONE);
    rd_en     = issue && real_rd;
    pass_done = (state == DRAIN) && accept_last;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      rd_addr      <= '0;
      v_reg        <= '0;
      p_reg        <= '0;
      elem         <= '0;
      pass_cnt     <= '0;
      cfg_err      <= 1'b0;
      rd_pending   <= 1'b0;
      last_pending <= 1'b0;
      swap_flag    <= 1'b0;
`ifdef I2C_WGT_ZEROPAD_EN
      e_reg        <= '0;
      pad_pending  <= 1'b0;
`endif
    end else begin
      rd_pending   <= issue;
      last_pending <= issue && elem_last;
`ifdef I2C_WGT_ZEROPAD_EN
      pad_pending  <= issue && !real_rd;
`endif
      if (rd_en) rd_addr <= rd_addr + ADDR_WID'(1);
      if (issue) elem <= elem_last ? '0 : elem + FW'(1);
      if (pass_done) pass_cnt <= pass_cnt + CHN_WID'(1);
      // Sticky ack: an ack coinciding with pass_done or arriving early in HOLD is kept.
      if (nxt == RUN) swap_flag <= 1'b0;
      else if (swap_ack && (pass_done || state == HOLD)) swap_flag <= 1'b1;
      if (state == IDLE && start) begin
        v_reg    <= v_calc;
        p_reg    <= num_passes;
        elem     <= '0;
        pass_cnt <= '0;
        rd_addr  <= '0;
        cfg_err  <= cfg_bad;
`ifdef I2C_WGT_ZEROPAD_EN
        e_reg    <= e_calc;
`endif
      end
    end
  end

  i2c_skid_fifo #(.WID(VW + 1)) u_skid (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (rd_pending),
    .in_data   (fifo_in),
    .out_valid (fifo_vld),
    .out_ready (out_ready),
    .out_data  (fifo_out),
    .count     (occ)
  );

  assign out_valid = fifo_vld;
  assign out_data  = fifo_out[VW-1:0];
  assign out_last  = fifo_out[VW];
endmodule

// File: tb/tb_img2col_weight_pp.sv
// Table-driven bench for img2col_weight_pp with a registered upstream buffer model.
module tb_img2col_weight_pp;
  import i2c_pkg::*;

  localparam int VW     = 128;
  localparam int BUDGET = 4000;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    chn_per_pass = '0;
  logic [3:0]    num_passes = '0;
  logic [3:0]    kernel_size = '0;
  logic          busy, done, cfg_err, rd_en;
  logic [9:0]    rd_addr;
  logic [VW-1:0] rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [VW-1:0] out_data;
  logic          out_last, pass_done;
  logic          swap_ack = 1'b0;

  img2col_weight_pp dut (
    .clock(clock), .rst_n(rst_n), .start(start),
    .chn_per_pass(chn_per_pass), .num_passes(num_passes), .kernel_size(kernel_size),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .pass_done(pass_done), .swap_ack(swap_ack)
  );

  always #5 clock = ~clock;

  function automatic logic [VW-1:0] vec_of(input int a);
    lane_vec_t v;
    for (int l = 0; l < 8; l++) v[l] = 16'(a*16 + l + 1);
    return v;
  endfunction

  // Upstream kernel-set buffers: data one cycle after the read strobe.
  always @(posedge clock) if (rd_en) rd_data <= vec_of(int'(rd_addr));

  typedef struct {
    int c, p, k, ready_mode, swap_dly;
    int exp_reads, exp_vecs, exp_passes, exp_err;
  } row_t;

  row_t rows[12];
  int n_pass = 0, n_total = 0;

  int cyc, nreads, nvec, nreal, npass, ndone, done_cfg;
  int exp_addr, data_idx, vin, e_exp, v_exp, p_exp, swap_dly;
  int pd_cyc, swap_at, exp_rd_cyc;
  int addr_err, data_err, stab_err, hold_err, turn_err, out_err, tim_err;
  bit legal, in_hold, prev_stall, prev_last, done_seen, timed_out;
  logic [VW-1:0] prev_dat;

  function automatic int pv(input int nopad, input int padded);
`ifdef I2C_WGT_ZEROPAD_EN
    return padded;
`else
    return nopad;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic observe();
    logic [VW-1:0] ev;
    if (rd_en) begin
      if (in_hold) hold_err++;
      if (nreads - nreal >= 2) out_err++;
      if (rd_addr != 10'(exp_addr)) addr_err++;
      exp_addr++;
      nreads++;
    end
    if (exp_rd_cyc == cyc) begin
      if (!rd_en) turn_err++;
      exp_rd_cyc = -1;
    end
    if (prev_stall && (!out_valid || out_data != prev_dat || out_last != prev_last)) stab_err++;
    prev_stall = out_valid && !out_ready;
    prev_dat   = out_data;
    prev_last  = out_last;
    if (out_valid && out_ready) begin
      if (vin < e_exp) begin
        ev = vec_of(data_idx);
        data_idx++;
        nreal++;
      end else begin
        ev = '0;
      end
      if (out_data != ev || out_last != (vin == v_exp - 1)) data_err++;
      vin = (vin == v_exp - 1) ? 0 : vin + 1;
      nvec++;
    end
    if (pass_done) begin
      if (!(out_valid && out_ready && out_last)) tim_err++;
      npass++;
      pd_cyc = cyc;
      if (npass < p_exp) begin
        in_hold = 1'b1;
        swap_at = cyc + swap_dly;
      end
    end
    if (in_hold && swap_ack) begin
      exp_rd_cyc = (cyc == pd_cyc) ? cyc + 2 : cyc + 1;
      in_hold = 1'b0;
    end
    if (cyc == 1) begin
      if (legal) begin
        if (!busy || !rd_en || cfg_err) tim_err++;
      end else if (!done || !cfg_err || busy) begin
        tim_err++;
      end
    end
    if (cyc == 2 && legal && !out_valid) tim_err++;
    if (done) begin
      ndone++;
      done_cfg = int'(cfg_err);
      done_seen = 1'b1;
      if (legal && cyc != pd_cyc + 1) tim_err++;
    end
  endtask

  task automatic run_job(input row_t r, input int abort_vec, output bit aborted);
    nreads = 0; nvec = 0; nreal = 0; npass = 0; ndone = 0; done_cfg = -1;
    exp_addr = 0; data_idx = 0; vin = 0;
    addr_err = 0; data_err = 0; stab_err = 0; hold_err = 0; turn_err = 0; out_err = 0; tim_err = 0;
    pd_cyc = -10; swap_at = -1; exp_rd_cyc = -1;
    in_hold = 1'b0; prev_stall = 1'b0; done_seen = 1'b0; aborted = 1'b0;
    e_exp = r.c * r.k * r.k;
`ifdef I2C_WGT_ZEROPAD_EN
    v_exp = ((e_exp + 7) / 8) * 8;
`else
    v_exp = e_exp;
`endif
    p_exp = r.p;
    swap_dly = r.swap_dly;
    legal = (r.exp_err == 0);
    cyc = 0;
    while (cyc < BUDGET && !done_seen && !aborted) begin
      @(posedge clock); #1;
      start = (cyc == 0);
      if (cyc == 0) begin
        chn_per_pass = 4'(r.c);
        num_passes   = 4'(r.p);
        kernel_size  = 4'(r.k);
      end
      out_ready = (r.ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      swap_ack  = (r.swap_dly == 0) ? 1'b1 : (cyc == swap_at);
      @(negedge clock);
      observe();
      if (abort_vec != 0 && nvec >= abort_vec) aborted = 1'b1;
      cyc++;
    end
    timed_out = !done_seen && !aborted;
    @(posedge clock); #1;
    start = 1'b0; swap_ack = 1'b0; out_ready = 1'b1;
  endtask

  task automatic run_row(input row_t r, input string tag);
    bit ab;
    run_job(r, 0, ab);
    check({tag, "_timeout"}, int'(timed_out), 0);
    check({tag, "_reads"}, nreads, r.exp_reads);
    check({tag, "_vectors"}, nvec, r.exp_vecs);
    check({tag, "_passes"}, npass, r.exp_passes);
    check({tag, "_done_cnt"}, ndone, 1);
    check({tag, "_cfg_err"}, done_cfg, r.exp_err);
    check({tag, "_addr_err"}, addr_err, 0);
    check({tag, "_data_err"}, data_err, 0);
    check({tag, "_stall_err"}, stab_err, 0);
    check({tag, "_hold_err"}, hold_err + turn_err, 0);
    check({tag, "_outstanding"}, out_err, 0);
    check({tag, "_timing"}, tim_err, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check({tag, "_cfg_err_hold"}, int'(cfg_err), r.exp_err);
  endtask

  initial begin
    bit ab;
    //            C   P   K  rdy swap reads vectors         passes err
    rows[0]  = '{ 2,  1,  3,  0,  1,  18,  pv(18, 24),    1,  0};
    rows[1]  = '{ 1,  3,  3,  0,  5,  27,  pv(27, 48),    3,  0};
    rows[2]  = '{ 4,  1,  3,  1,  1,  36,  pv(36, 40),    1,  0};
    rows[3]  = '{ 1,  1,  0,  0,  1,   0,  0,             0,  1};
    rows[4]  = '{15, 15, 15,  0,  1,   0,  0,             0,  1};
    rows[5]  = '{ 0,  1,  3,  0,  1,   0,  0,             0,  1};
    rows[6]  = '{ 1,  0,  3,  0,  1,   0,  0,             0,  1};
    rows[7]  = '{ 8,  2,  8,  0,  1, 1024, pv(1024, 1024), 2,  0};
    rows[8]  = '{ 9,  2,  8,  0,  1,   0,  0,             0,  1};
    rows[9]  = '{ 1,  2,  1,  0,  0,   2,  pv(2, 16),     2,  0};
    rows[10] = '{ 8,  2,  4,  1,  2, 256,  pv(256, 256),  2,  0};
    rows[11] = '{ 1,  1,  3,  0,  1,   9,  pv(9, 16),     1,  0};

    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
    @(negedge clock);
    check("rst_ctrl", int'({busy, done, cfg_err, rd_en, out_valid, out_last, pass_done}), 0);
    check("rst_addr", int'(rd_addr), 0);
    check("rst_data_zero", int'(out_data == '0), 1);

    for (int i = 0; i < 12; i++) run_row(rows[i], $sformatf("row%0d", i));

    // Abort in RUN after the 7th vector; the next cycle must show reset values.
    run_job(rows[0], 7, ab);
    check("abort_reached", int'(ab), 1);
    check("abort_no_done", ndone, 0);
    rst_n = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(negedge clock);
    check("abort_rst_ctrl", int'({busy, done, cfg_err, rd_en, out_valid, out_last, pass_done}), 0);
    check("abort_rst_addr", int'(rd_addr), 0);
    check("abort_rst_data_zero", int'(out_data == '0), 1);
    run_row(rows[0], "rerun");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
